// File: rtl/sseg_scan_ctrl.sv
// Four-digit multiplexed seven-segment scan controller with anti-ghosting blank
// interval, frame-coherent input snapshot, leading-zero suppression and per-digit enables.
module sseg_scan_ctrl #(
    parameter int SLOT_TICKS  = 4,
    parameter int BLANK_TICKS = 1
) (
    input  logic        clock,
    input  logic        greset,
    input  logic        tick,
    input  logic [15:0] value,
    input  logic [3:0]  dp_in,
    input  logic [3:0]  digit_en,
    input  logic        lz_suppress,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [1:0]  digit_idx,
    output logic        frame_done
);

    localparam int CNT_W = $clog2(SLOT_TICKS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SLOT_TICKS - 1);

    logic [CNT_W-1:0] cnt_reg;
    logic [1:0]       digit_reg;
    logic [15:0]      snap_value_reg;
    logic [3:0]       snap_dp_reg;
    logic [3:0]       snap_en_reg;
    logic             snap_lz_reg;
    logic             frame_end_reg;

    logic [3:0]       an_reg;
    logic [6:0]       seg_reg;
    logic             dp_reg;
    logic [1:0]       digit_idx_reg;
    logic             frame_done_reg;

    logic             slot_last;
    logic             frame_end;
    logic             blank_phase;
    logic [3:0]       nib_zero;
    logic [3:0]       suppress;
    logic [3:0]       digit_lit;
    logic [6:0]       digit_seg [4];
    logic             lit_next;
    logic [3:0]       an_next;
    logic [6:0]       seg_next;
    logic             dp_next;

    function automatic logic [6:0] hex_decode(input logic [3:0] nib);
        logic [6:0] s;
        s = 7'b1111111;
        case (nib)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            4'hF: s = 7'b0001110;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    assign slot_last = (cnt_reg == CNT_LAST);
    assign frame_end = tick && slot_last && (digit_reg == 2'd3);

    // Scan position and snapshot; inputs are only captured at the frame boundary
    always_ff @(posedge clock or posedge greset) begin
        if (greset) begin
            cnt_reg        <= '0;
            digit_reg      <= 2'd0;
            snap_value_reg <= 16'h0000;
            snap_dp_reg    <= 4'h0;
            snap_en_reg    <= 4'h0;
            snap_lz_reg    <= 1'b0;
            frame_end_reg  <= 1'b0;
        end else begin
            frame_end_reg <= frame_end;
            if (tick) begin
                if (slot_last) begin
                    cnt_reg   <= '0;
                    digit_reg <= digit_reg + 2'd1;
                end else begin
                    cnt_reg <= cnt_reg + CNT_W'(1);
                end
            end
            if (frame_end) begin
                snap_value_reg <= value;
                snap_dp_reg    <= dp_in;
                snap_en_reg    <= digit_en;
                snap_lz_reg    <= lz_suppress;
            end
        end
    end

    generate
        if (BLANK_TICKS == 0) begin : g_no_blank
            assign blank_phase = 1'b0;
        end else begin : g_blank
            assign blank_phase = (cnt_reg < CNT_W'(BLANK_TICKS));
        end
    endgenerate

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_digit
            assign nib_zero[gi]  = (snap_value_reg[4*gi +: 4] == 4'h0);
            assign digit_seg[gi] = hex_decode(snap_value_reg[4*gi +: 4]);
            assign digit_lit[gi] = snap_en_reg[gi] && !suppress[gi];
        end
        // A digit is a leading zero only if it and every digit above it are zero
        assign suppress[0] = 1'b0;
        for (gi = 1; gi < 4; gi++) begin : g_supp
            assign suppress[gi] = snap_lz_reg && (&nib_zero[3:gi]);
        end
    endgenerate

    always_comb begin
        lit_next = !blank_phase && digit_lit[digit_reg];
        an_next  = 4'b1111;
        seg_next = 7'b1111111;
        dp_next  = 1'b1;
        if (lit_next) begin
            an_next  = ~(4'b0001 << digit_reg);
            seg_next = digit_seg[digit_reg];
            dp_next  = ~snap_dp_reg[digit_reg];
        end
    end

    // Output stage: one register after the scan state
    always_ff @(posedge clock or posedge greset) begin
        if (greset) begin
            an_reg         <= 4'b1111;
            seg_reg        <= 7'b1111111;
            dp_reg         <= 1'b1;
            digit_idx_reg  <= 2'd0;
            frame_done_reg <= 1'b0;
        end else begin
            an_reg         <= an_next;
            seg_reg        <= seg_next;
            dp_reg         <= dp_next;
            digit_idx_reg  <= digit_reg;
            frame_done_reg <= frame_end_reg;
        end
    end

    assign an         = an_reg;
    assign seg        = seg_reg;
    assign dp         = dp_reg;
    assign digit_idx  = digit_idx_reg;
    assign frame_done = frame_done_reg;

endmodule
